// File: rtl/mux_scan_nx1_if.sv
// mux_scan_nx1_if: channel bus for the registered scanning CH:1 multiplexer.
//   master drives: A (packed channel data), sel, mode, en, dwell, ch_mask
//   slave drives : Y (registered sample), Y_valid, cur_ch, wrap
interface mux_scan_nx1_if #(
  parameter int CH      = 8,
  parameter int W       = 8,
  parameter int SELW    = 3,
  parameter int DWELL_W = 8
) ();
  logic [CH*W-1:0]    A;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic               en;
  logic [DWELL_W-1:0] dwell;
  logic [CH-1:0]      ch_mask;
  logic [W-1:0]       Y;
  logic               Y_valid;
  logic [SELW-1:0]    cur_ch;
  logic               wrap;

  modport master (output A, sel, mode, en, dwell, ch_mask,
                  input  Y, Y_valid, cur_ch, wrap);
  modport slave  (input  A, sel, mode, en, dwell, ch_mask,
                  output Y, Y_valid, cur_ch, wrap);
endinterface

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered CH:1 multiplexer of W-bit channels.
//   Manual mode (mode=0) samples the channel given by sel; scan mode (mode=1)
//   sweeps the channels enabled in ch_mask, holding each for dwell+1 cycles.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of mux_scan_nx1_if (A, sel, mode, en, dwell, ch_mask in;
//           Y, Y_valid, cur_ch, wrap out, all registered)
module mux_scan_nx1 #(
  parameter int CH      = 8,
  parameter int W       = 8,
  parameter int SELW    = 3,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_nx1_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [W-1:0]       y_r, y_nx_s;
  logic               y_valid_r, y_valid_nx_s;
  logic [SELW-1:0]    cur_ch_r, cur_ch_nx_s;
  logic               wrap_r, wrap_nx_s;
  logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nx_s;

  logic [SELW-1:0]    lowest_s;       // lowest enabled channel
  logic [SELW-1:0]    above_s;        // lowest enabled channel above cur_ch
  logic               above_found_s;  // clear means the next step wraps
  logic               cur_en_s;       // current channel is still in the sweep
  logic               any_en_s;
  logic               sel_ok_s;

  // Data of channel idx; indices >= CH read as zero.
  function automatic logic [W-1:0] chan_data(input logic [CH*W-1:0] a,
                                             input logic [SELW-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      r = (idx == SELW'(k)) ? a[k*W +: W] : r;
    end
    return r;
  endfunction

  assign any_en_s = |bus.ch_mask;
  assign sel_ok_s = (32'(bus.sel) < CH);

  // Mask search: walking downwards, the last hit is the lowest qualifying channel.
  always_comb begin
    lowest_s      = '0;
    above_s       = '0;
    above_found_s = 1'b0;
    cur_en_s      = 1'b0;
    for (int k = CH - 1; k >= 0; k--) begin
      lowest_s      = bus.ch_mask[k] ? SELW'(k) : lowest_s;
      above_s       = (bus.ch_mask[k] && (SELW'(k) > cur_ch_r)) ? SELW'(k) : above_s;
      above_found_s = (bus.ch_mask[k] && (SELW'(k) > cur_ch_r)) ? 1'b1 : above_found_s;
      cur_en_s      = (bus.ch_mask[k] && (SELW'(k) == cur_ch_r)) ? 1'b1 : cur_en_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: en and mode are re-evaluated on every edge.
  always_comb begin
    case ({bus.en, bus.mode})
      2'b10:   state_nx_s = MANUAL;
      2'b11:   state_nx_s = SCAN;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the registered outputs for the state being entered.
  always_comb begin
    y_nx_s         = y_r;
    y_valid_nx_s   = 1'b0;
    cur_ch_nx_s    = cur_ch_r;
    wrap_nx_s      = 1'b0;
    dwell_cnt_nx_s = '0;
    case (state_nx_s)
      MANUAL: begin
        cur_ch_nx_s  = bus.sel;
        y_nx_s       = sel_ok_s ? chan_data(bus.A, bus.sel) : '0;
        y_valid_nx_s = sel_ok_s;
      end
      SCAN: begin
        if (state_r != SCAN) begin
          // Entry cycle: restart the sweep, no valid sample yet.
          cur_ch_nx_s = any_en_s ? lowest_s : cur_ch_r;
        end else if (!any_en_s) begin
          dwell_cnt_nx_s = dwell_cnt_r;
        end else begin
          y_nx_s       = chan_data(bus.A, cur_ch_r);
          y_valid_nx_s = 1'b1;
          // A channel dropped from the mask is left at once; a shrunken
          // dwell (count already past it) counts as expiry.
          if (!cur_en_s || (dwell_cnt_r >= bus.dwell)) begin
            cur_ch_nx_s = above_found_s ? above_s : lowest_s;
            wrap_nx_s   = ~above_found_s;
          end else begin
            dwell_cnt_nx_s = dwell_cnt_r + DWELL_W'(1);
          end
        end
      end
      default: begin
        y_nx_s = y_r;
      end
    endcase
  end

  // Output and dwell-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= '0;
      y_valid_r   <= 1'b0;
      cur_ch_r    <= '0;
      wrap_r      <= 1'b0;
      dwell_cnt_r <= '0;
    end else begin
      y_r         <= y_nx_s;
      y_valid_r   <= y_valid_nx_s;
      cur_ch_r    <= cur_ch_nx_s;
      wrap_r      <= wrap_nx_s;
      dwell_cnt_r <= dwell_cnt_nx_s;
    end
  end

  assign bus.Y       = y_r;
  assign bus.Y_valid = y_valid_r;
  assign bus.cur_ch  = cur_ch_r;
  assign bus.wrap    = wrap_r;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: directed and random stimulus for two instances (CH=8 and
// CH=6) checked cycle by cycle against a channel-list reference model.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a_v = 64'd0;
  logic [2:0]  sel_v = 3'd0;
  logic        mode_v = 1'b0;
  logic        en_v = 1'b0;
  logic [7:0]  dwell_v = 8'd0;
  logic [7:0]  mask_v = 8'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_scan_nx1_if #(.CH(8), .W(8), .SELW(3), .DWELL_W(8)) bus8 ();
  mux_scan_nx1_if #(.CH(6), .W(8), .SELW(3), .DWELL_W(8)) bus6 ();

  assign bus8.A = a_v;        assign bus6.A = a_v[47:0];
  assign bus8.sel = sel_v;    assign bus6.sel = sel_v;
  assign bus8.mode = mode_v;  assign bus6.mode = mode_v;
  assign bus8.en = en_v;      assign bus6.en = en_v;
  assign bus8.dwell = dwell_v; assign bus6.dwell = dwell_v;
  assign bus8.ch_mask = mask_v; assign bus6.ch_mask = mask_v[5:0];

  mux_scan_nx1 #(.CH(8), .W(8), .SELW(3), .DWELL_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  mux_scan_nx1 #(.CH(6), .W(8), .SELW(3), .DWELL_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6.slave));

  // Reference state: st 0=idle 1=manual 2=scan.
  typedef struct {
    int st; int y; int yv; int cur; int wrap; int cnt;
  } mdl_t;

  mdl_t m8, m6;
  localparam mdl_t MDL_RST = '{st: 0, y: 0, yv: 0, cur: 0, wrap: 0, cnt: 0};

  function automatic int chan(int k);
    return int'((a_v >> (8 * k)) & 64'hFF);
  endfunction

  // One clock edge of the behaviour, using the sweep as a list of channels.
  function automatic mdl_t mstep(mdl_t m, int nch);
    mdl_t n;
    int   q[$];
    int   nxt;
    bit   found;
    bit   cur_on;
    n = m;
    n.wrap = 0;
    if (!en_v) begin
      n.st = 0; n.yv = 0; n.cnt = 0;
    end else if (!mode_v) begin
      n.st = 1; n.cur = int'(sel_v); n.cnt = 0;
      if (int'(sel_v) < nch) begin n.y = chan(int'(sel_v)); n.yv = 1; end
      else begin n.y = 0; n.yv = 0; end
    end else begin
      for (int k = 0; k < nch; k++) if (mask_v[k]) q.push_back(k);
      if (m.st != 2) begin
        n.st = 2; n.cnt = 0; n.yv = 0;
        if (q.size() > 0) n.cur = q[0];
      end else if (q.size() == 0) begin
        n.yv = 0;
      end else begin
        n.y = (m.cur < nch) ? chan(m.cur) : 0;
        n.yv = 1;
        cur_on = 0;
        foreach (q[i]) if (q[i] == m.cur) cur_on = 1;
        if (!cur_on || m.cnt >= int'(dwell_v)) begin
          found = 0; nxt = 0;
          foreach (q[i]) if (!found && q[i] > m.cur) begin nxt = q[i]; found = 1; end
          if (!found) begin nxt = q[0]; n.wrap = 1; end
          n.cur = nxt; n.cnt = 0;
        end else begin
          n.cnt = m.cnt + 1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("y8",    {24'd0, bus8.Y},       m8.y);
    chk("yv8",   {31'd0, bus8.Y_valid}, m8.yv);
    chk("cur8",  {29'd0, bus8.cur_ch},  m8.cur);
    chk("wrap8", {31'd0, bus8.wrap},    m8.wrap);
    chk("y6",    {24'd0, bus6.Y},       m6.y);
    chk("yv6",   {31'd0, bus6.Y_valid}, m6.yv);
    chk("cur6",  {29'd0, bus6.cur_ch},  m6.cur);
    chk("wrap6", {31'd0, bus6.wrap},    m6.wrap);
  endtask

  task automatic cycle();
    @(posedge clk);
    m8 = mstep(m8, 8);
    m6 = mstep(m6, 6);
    #1;
    check_all();
  endtask

  int exp_seq[13] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 7, 7, 7, 0};
  int wraps;
  int n;

  initial begin
    m8 = MDL_RST; m6 = MDL_RST;
    for (int k = 0; k < 8; k++) a_v[8*k +: 8] = 8'h10 + 8'(k);
    #3;
    check_all();
    @(posedge clk); #2; rst_n = 1'b1;

    // Manual sweep, one sel per cycle; CH=6 instance rejects sel 6 and 7.
    en_v = 1'b1; mode_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sel_v = 3'(k);
      cycle();
      chk("man_y8", {24'd0, bus8.Y}, 32'h10 + 32'(k));
      chk("man_yv8", {31'd0, bus8.Y_valid}, 32'd1);
    end
    chk("man_oor_y6", {24'd0, bus6.Y}, 32'd0);
    chk("man_oor_yv6", {31'd0, bus6.Y_valid}, 32'd0);

    // Scan 0,2,5,7 with dwell 2.
    mode_v = 1'b1; mask_v = 8'b1010_0101; dwell_v = 8'd2;
    wraps = 0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      chk("scan_seq", {29'd0, bus8.cur_ch}, 32'(exp_seq[i]));
      if (i > 0) wraps += int'(bus8.wrap);
    end
    chk("scan_wraps", 32'(wraps), 32'd1);

    // Single channel with dwell 0 wraps every cycle.
    dwell_v = 8'd0; mask_v = 8'b0001_0000;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("single_wrap", {31'd0, bus8.wrap}, 32'd1);
      chk("single_cur", {29'd0, bus8.cur_ch}, 32'd4);
    end

    // Empty mask holds Y and drops valid.
    mask_v = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("empty_y", {24'd0, bus8.Y}, 32'h14);
      chk("empty_yv", {31'd0, bus8.Y_valid}, 32'd0);
    end

    // Drop channel 2 from the mask mid-dwell.
    mask_v = 8'b0000_1101; dwell_v = 8'd9;
    n = 0;
    cycle();
    while (!(m8.cur == 2 && m8.cnt == 3) && n < 40) begin
      cycle();
      n++;
    end
    chk("mask_wait_timeout", 32'(n < 40), 32'd1);
    mask_v = 8'b0000_1001;
    cycle();
    chk("mask_clear_ch", {29'd0, bus8.cur_ch}, 32'd3);

    // Disable: Y held, valid dropped.
    en_v = 1'b0;
    cycle();
    chk("idle_y", {24'd0, bus8.Y}, 32'h12);
    chk("idle_yv", {31'd0, bus8.Y_valid}, 32'd0);

    // Manual then switch to scan.
    en_v = 1'b1; mode_v = 1'b0; sel_v = 3'd3;
    cycle();
    mode_v = 1'b1; mask_v = 8'b1010_0100; dwell_v = 8'd1;
    cycle();
    chk("entry_cur", {29'd0, bus8.cur_ch}, 32'd2);
    chk("entry_yv", {31'd0, bus8.Y_valid}, 32'd0);
    cycle();
    chk("entry_next_y", {24'd0, bus8.Y}, 32'h12);
    chk("entry_next_yv", {31'd0, bus8.Y_valid}, 32'd1);

    // Random phase.
    for (int i = 0; i < 300; i++) begin
      a_v     = {$urandom, $urandom};
      en_v    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode_v = ~mode_v;
      sel_v   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dwell_v = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) mask_v = 8'($urandom_range(0, 255));
      cycle();
    end

    // Asynchronous reset mid-cycle while scanning.
    for (int k = 0; k < 8; k++) a_v[8*k +: 8] = 8'h10 + 8'(k);
    en_v = 1'b1; mode_v = 1'b1; mask_v = 8'hFF; dwell_v = 8'd1;
    for (int i = 0; i < 5; i++) cycle();
    #2; rst_n = 1'b0;
    #1;
    m8 = MDL_RST; m6 = MDL_RST;
    check_all();
    #1; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
